booth_enc_seq: RTL and testbench
================================

Name: booth_enc_seq

Overview:
- Sequential radix-4 Booth recoder for the 11-bit multiplier datapath.
- Accepts one multiplier operand per transaction.
- Emits one 3-bit Booth select code per cycle, least-significant group first, over a valid/ready stream. Each code drives the partial-product select mux directly.
- The select-code encoding matches the partial-product mux one-for-one: 000 = 0, 001/010 = +A, 011 = +2A, 100 = -2A (inverted), 101/110 = -A (inverted), 111 = 0 (all ones).
- Also emits the two's-complement correction bit (neg) for each group.

Parameters:
- OP_W, 11, multiplier operand width; fixed at 11 for this datapath.
- NGRP, 6, number of Booth groups; equals OP_W/2+1, rounded down.
- SIGNED, 0, 1 = sign-extend the operand into bit 11; 0 = zero-extend.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- in_valid  input  1  scnd_op is valid.
- in_ready  output  1  block can accept an operand.
- scnd_op  input  11  multiplier operand.
- out_valid  output  1  sel, neg, idx, last and nz_cnt are valid.
- out_ready  input  1  consumer accepts the current group.
- sel  output  3  Booth select code for group idx.
- neg  output  1  correction bit; equals sel[2].
- idx  output  3  group index, 0..5; weight is 4^idx.
- last  output  1  high on group 5.
- nz_cnt  output  3  count of non-zero groups (sel not 000/111) for the whole operand; valid when last=1.

Behaviour:
- Reset: a clock edge with rst=0 forces the following values, regardless of any other input.
  - state=IDLE.
  - out_valid=0, sel=000, neg=0, idx=0, last=0, nz_cnt=0.
  - in_valid is ignored while rst=0.
  - in_ready=1 from the first cycle after reset deasserts.
- States: IDLE and ENC.
  - in_ready = (state==IDLE).
  - out_valid = (state==ENC).
- IDLE:
  - On in_valid && in_ready at edge t, load the 13-bit shift register sr = {ext, scnd_op[10:0], 1'b0}.
    - ext = scnd_op[10] when SIGNED=1, else 0.
  - Set idx=0, compute nz_cnt, go to ENC.
  - First group is presented in cycle t+1.
- ENC:
  - sel = sr[2:0], neg = sr[2], last = (idx==5). All outputs come from registered state.
  - On out_valid && out_ready: sr shifts right by 2 (upper bits filled with ext), idx increments.
  - If last, go to IDLE instead.
  - There is no bubble between groups: one group per cycle under continuous out_ready.
  - Transaction throughput: 6 groups per 7 cycles, because of the IDLE accept cycle.
- Backpressure: while out_valid=1 and out_ready=0, sel, neg, idx, last and nz_cnt hold stable.
- nz_cnt:
  - Computed from the full extended operand at load time.
  - Constant for the whole transaction.
  - Range 0..6; fits 3 bits.
- Simultaneous events:
  - in_valid while in ENC is not accepted (in_ready=0). The source must hold the operand.
  - The last handshake and a new in_valid in the same cycle: the new operand is accepted on the next edge, from IDLE.
- Reset mid-transaction: the transaction is abandoned with no further groups emitted, and the reset values above apply.
- Arithmetic invariant: sum over i of value(sel_i)*4^i equals the extended operand, where value() is the Booth digit in {-2..+2}.

Test Plan:
- Reset then scnd_op=11'h000, SIGNED=0 -> 6 groups; sel=000 and neg=0 each; idx 0..5; last only on idx 5; nz_cnt=0.
- scnd_op=11'd1, SIGNED=0 -> g0 sel=010; g1..g5 sel=000; nz_cnt=1; first out_valid exactly one cycle after the input handshake.
- scnd_op=11'h7FF with SIGNED=1 versus SIGNED=0:
  - SIGNED=1: g0=110 (neg=1), g1..g5=111; nz_cnt=1.
  - SIGNED=0: g0=110, g1..g4=111, g5=011; nz_cnt=2.
- scnd_op=11'h2AA, SIGNED=0 -> g0=100 (neg=1), g1..g4=101, g5=001; nz_cnt=6. Digit-weighted sum equals 682.
- Backpressure: out_ready=0 for 3 cycles at idx=2 -> sel/idx/last stable; in_ready=0 throughout; resumes at idx=3 when out_ready=1.
- Reset mid-stream: rst=0 for one cycle while idx=3 -> next cycle out_valid=0, in_ready=1, sel=000. A new operand 11'd1 then encodes correctly from g0.

Source files
------------

// File: rtl/booth_enc_seq_if.sv
// booth_enc_seq_if
// Handshake and data bundle between a multiplier-operand source, the
// sequential radix-4 Booth recoder and the partial-product consumer.
//
// Signals:
//   in_valid   source -> recoder   scnd_op is valid
//   in_ready   recoder -> source   recoder can accept an operand
//   scnd_op    source -> recoder   multiplier operand (OP_W bits)
//   out_valid  recoder -> consumer sel/neg/idx/last/nz_cnt are valid
//   out_ready  consumer -> recoder consumer takes the current group
//   sel        recoder -> consumer 3-bit Booth select code
//   neg        recoder -> consumer two's-complement correction bit
//   idx        recoder -> consumer group index, weight 4^idx
//   last       recoder -> consumer high on the final group
//   nz_cnt     recoder -> consumer non-zero group count for the operand
//
// Modports:
//   master  the testbench/system side that drives operands and ready
//   slave   the recoder itself
interface booth_enc_seq_if #(
    parameter int OP_W = 11
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] scnd_op;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      sel;
    logic            neg;
    logic [2:0]      idx;
    logic            last;
    logic [2:0]      nz_cnt;

    modport master (
        output in_valid, scnd_op, out_ready,
        input  in_ready, out_valid, sel, neg, idx, last, nz_cnt
    );

    modport slave (
        input  in_valid, scnd_op, out_ready,
        output in_ready, out_valid, sel, neg, idx, last, nz_cnt
    );
endinterface

// File: rtl/booth_enc_seq.sv
// booth_enc_seq
// Sequential radix-4 Booth recoder. One operand is accepted per
// transaction; the recoder then emits one 3-bit select code per cycle,
// least-significant group first, together with the correction bit, the
// group index, a last flag and the count of non-zero groups.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-low
//   bus   booth_enc_seq_if.slave (operand stream in, group stream out)
//
// Parameters:
//   OP_W    operand width (11 for this datapath)
//   NGRP    number of Booth groups (OP_W/2+1)
//   SIGNED  1 = sign-extend operand into the guard bit, 0 = zero-extend
module booth_enc_seq #(
    parameter int OP_W   = 11,
    parameter int NGRP   = 6,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst,
    booth_enc_seq_if.slave  bus
);

    // Shift register holds {ext, operand, implicit 0 below the LSB}.
    localparam int SR_W = OP_W + 2;

    typedef enum logic {
        IDLE,
        ENC
    } state_t;

    state_t          r_state;
    logic [SR_W-1:0] r_sr;
    logic [2:0]      r_idx;
    logic [2:0]      r_nzCnt;
    logic            r_last;
    logic            r_inReady;
    logic            r_outValid;

    logic            w_ext;
    logic [SR_W-1:0] w_load;
    logic [2:0]      w_loadNz;
    logic            w_accept;
    logic            w_advance;

    // A group whose three bits are all equal recodes to digit 0; every
    // other pattern is a non-zero digit.
    function automatic logic [2:0] countNz(input logic [SR_W-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (v[2*g +: 3] != 3'b000 && v[2*g +: 3] != 3'b111) begin
                c = c + 3'd1;
            end
        end
        return c;
    endfunction

    assign w_ext     = (SIGNED != 0) ? bus.scnd_op[OP_W-1] : 1'b0;
    assign w_load    = {w_ext, bus.scnd_op, 1'b0};
    assign w_loadNz  = countNz(w_load);
    assign w_accept  = bus.in_valid && r_inReady;
    assign w_advance = r_outValid && bus.out_ready;

    // Control and datapath state. The top bit of the shift register is the
    // extension bit, so refilling from it reproduces the extension in both
    // the signed and unsigned configurations.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_idx      <= '0;
            r_nzCnt    <= '0;
            r_last     <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sr       <= w_load;
                        r_idx      <= '0;
                        r_nzCnt    <= w_loadNz;
                        r_last     <= (NGRP == 1);
                        r_inReady  <= 1'b0;
                        r_outValid <= 1'b1;
                        r_state    <= ENC;
                    end
                end
                ENC: begin
                    if (w_advance) begin
                        r_sr <= {r_sr[SR_W-1], r_sr[SR_W-1], r_sr[SR_W-1:2]};
                        if (r_last) begin
                            r_idx      <= '0;
                            r_last     <= 1'b0;
                            r_inReady  <= 1'b1;
                            r_outValid <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_idx  <= r_idx + 3'd1;
                            r_last <= (r_idx == 3'(NGRP - 2));
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.sel       = r_sr[2:0];
    assign bus.neg       = r_sr[2];
    assign bus.idx       = r_idx;
    assign bus.last      = r_last;
    assign bus.nz_cnt    = r_nzCnt;

endmodule

// File: tb/tb_booth_enc_seq.sv
// tb_booth_enc_seq
// Testbench for booth_enc_seq. Two recoders are instantiated, one zero-
// extending and one sign-extending; a select flag routes the shared
// stimulus to one of them and muxes its outputs back for checking.
// Expected groups are queued when an operand is offered and compared as
// the recoder hands each group over.
module tb_booth_enc_seq;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        outReady;
    logic        useSigned;
    logic [10:0] scndOp;

    logic        mOutValid;
    logic        mInReady;
    logic        mNeg;
    logic        mLast;
    logic [2:0]  mSel;
    logic [2:0]  mIdx;
    logic [2:0]  mNz;

    typedef struct {
        logic [10:0] op;
        logic        sgn;
        logic [17:0] codes;
        int          nz;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        int         idx;
        logic       last;
        int         nz;
        logic       chk;
        int         extVal;
    } exp_t;

    vec_t vecs[5];
    exp_t expQ[$];

    int nVec;
    int nFail;
    int cyc;
    int acc;
    int acceptCyc;

    booth_enc_seq_if #(.OP_W(11)) bus0 ();
    booth_enc_seq_if #(.OP_W(11)) bus1 ();

    assign bus0.in_valid  = inValid && !useSigned;
    assign bus1.in_valid  = inValid && useSigned;
    assign bus0.scnd_op   = scndOp;
    assign bus1.scnd_op   = scndOp;
    assign bus0.out_ready = outReady;
    assign bus1.out_ready = outReady;

    assign mOutValid = useSigned ? bus1.out_valid : bus0.out_valid;
    assign mInReady  = useSigned ? bus1.in_ready  : bus0.in_ready;
    assign mNeg      = useSigned ? bus1.neg       : bus0.neg;
    assign mLast     = useSigned ? bus1.last      : bus0.last;
    assign mSel      = useSigned ? bus1.sel       : bus0.sel;
    assign mIdx      = useSigned ? bus1.idx       : bus0.idx;
    assign mNz       = useSigned ? bus1.nz_cnt    : bus0.nz_cnt;

    booth_enc_seq #(.OP_W(11), .NGRP(6), .SIGNED(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    booth_enc_seq #(.OP_W(11), .NGRP(6), .SIGNED(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Free-running clock and a cycle counter used for throughput timing.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Booth digit value for each select code, as the partial-product mux
    // interprets it.
    function automatic int digitValue(input logic [2:0] s);
        case (s)
            3'b001, 3'b010: return 1;
            3'b011:         return 2;
            3'b100:         return -2;
            3'b101, 3'b110: return -1;
            default:        return 0;
        endcase
    endfunction

    function automatic int extendOp(input logic [10:0] op, input logic sgn);
        if (sgn) return int'($signed(op));
        return int'(op);
    endfunction

    // Arithmetic recoding d_i = b(2i-1) + b(2i) - 2*b(2i+1) of the extended
    // operand; counts the digits that are not zero.
    function automatic int modelNz(input logic [10:0] op, input logic sgn);
        int x;
        int d;
        int lo;
        int n;
        x = extendOp(op, sgn);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            lo = (i == 0) ? 0 : ((x >>> (2*i - 1)) & 1);
            d  = lo + ((x >>> (2*i)) & 1) - 2 * ((x >>> (2*i + 1)) & 1);
            if (d != 0) n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVec++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offers one operand, queues its six expected groups, waits (bounded)
    // for the handshake and confirms the first group appears one cycle later.
    task automatic applyStimulus(input logic [10:0] op, input logic sgn,
                                 input logic chk, input logic [17:0] codes,
                                 input int nzExp);
        int   waitCyc;
        exp_t e;
        @(posedge clk);
        #1;
        useSigned = sgn;
        scndOp    = op;
        inValid   = 1'b1;
        waitCyc   = 0;
        @(negedge clk);
        while (!mInReady && waitCyc < 40) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!mInReady) begin
            checkOutput("acceptTimeout", 0, 1);
            inValid = 1'b0;
            return;
        end
        for (int g = 0; g < 6; g++) begin
            e.sel    = codes[3*g +: 3];
            e.idx    = g;
            e.last   = (g == 5);
            e.nz     = nzExp;
            e.chk    = chk;
            e.extVal = extendOp(op, sgn);
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        inValid   = 1'b0;
        @(negedge clk);
        checkOutput("firstValid", int'(mOutValid), 1);
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while ((expQ.size() != 0 || !mInReady) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("drainTimeout", expQ.size(), 0);
    endtask

    task automatic waitIdx(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(mOutValid && int'(mIdx) == target) && n < 20);
        if (n >= 20) checkOutput("idxTimeout", int'(mIdx), target);
    endtask

    // Scoreboard side: every group handed over is compared with the head of
    // the queue, and at the last group the weighted digit sum must rebuild
    // the extended operand.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            acc = 0;
        end else if (mOutValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedGroup", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("idx", int'(mIdx), e.idx);
                checkOutput("last", int'(mLast), int'(e.last));
                checkOutput("nzCnt", int'(mNz), e.nz);
                if (e.chk) begin
                    checkOutput("sel", int'(mSel), int'(e.sel));
                    checkOutput("neg", int'(mNeg), int'(e.sel[2]));
                end
                acc = acc + digitValue(mSel) * (4 ** e.idx);
                if (e.last) begin
                    checkOutput("digitSum", acc, e.extVal);
                    acc = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    // Main sequence: reset, table vectors, random operands, then the
    // back-to-back, backpressure and mid-stream reset corner cases.
    initial begin
        int t1;
        nVec      = 0;
        nFail     = 0;
        acc       = 0;
        acceptCyc = 0;
        rst       = 1'b0;
        inValid   = 1'b0;
        outReady  = 1'b1;
        useSigned = 1'b0;
        scndOp    = '0;

        vecs[0] = '{11'h000, 1'b0, 18'o000000, 0};
        vecs[1] = '{11'h001, 1'b0, 18'o000002, 1};
        vecs[2] = '{11'h7FF, 1'b1, 18'o777776, 1};
        vecs[3] = '{11'h7FF, 1'b0, 18'o377776, 2};
        vecs[4] = '{11'h2AA, 1'b0, 18'o155554, 6};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstOutValid", int'(mOutValid), 0);
        checkOutput("rstInReady", int'(mInReady), 1);
        checkOutput("rstSel", int'(mSel), 0);
        checkOutput("rstNeg", int'(mNeg), 0);
        checkOutput("rstIdx", int'(mIdx), 0);
        checkOutput("rstLast", int'(mLast), 0);
        checkOutput("rstNz", int'(mNz), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].op, vecs[i].sgn, 1'b1, vecs[i].codes, vecs[i].nz);
            waitDone();
        end

        for (int i = 0; i < 8; i++) begin
            logic [10:0] op;
            logic        sgn;
            op  = 11'($urandom);
            sgn = 1'(i % 2);
            applyStimulus(op, sgn, 1'b0, 18'o0, modelNz(op, sgn));
            waitDone();
        end

        applyStimulus(11'h155, 1'b0, 1'b0, 18'o0, modelNz(11'h155, 1'b0));
        t1 = acceptCyc;
        applyStimulus(11'h3C3, 1'b0, 1'b0, 18'o0, modelNz(11'h3C3, 1'b0));
        checkOutput("backToBackSpacing", acceptCyc - t1, 7);
        waitDone();

        applyStimulus(11'h2AA, 1'b0, 1'b1, 18'o155554, 6);
        waitIdx(2);
        outReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("stallSel", int'(mSel), 5);
            checkOutput("stallIdx", int'(mIdx), 2);
            checkOutput("stallLast", int'(mLast), 0);
            checkOutput("stallInReady", int'(mInReady), 0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resumeIdx", int'(mIdx), 3);
        waitDone();

        applyStimulus(11'h2AA, 1'b0, 1'b1, 18'o155554, 6);
        waitIdx(3);
        outReady = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.delete();
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("midRstOutValid", int'(mOutValid), 0);
        checkOutput("midRstInReady", int'(mInReady), 1);
        checkOutput("midRstSel", int'(mSel), 0);
        applyStimulus(11'h001, 1'b0, 1'b1, 18'o000002, 1);
        waitDone();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
